// File: rtl/cpu_mem_pkg.sv
// Shared constants and state type for the CPU memory responder.
package cpu_mem_pkg;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/cpu_memory_mem_array.sv
// One-write, two-read synchronous word store with write-first bypass on each read port.
module mem_array_1w2r #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re_a,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic          re_b,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);
    logic [DW-1:0] mem [0:(2**AW)-1];

    // The array itself is never reset; contents survive a reboot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) begin
                rdata_a <= (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
            end
            if (re_b) begin
                rdata_b <= (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];
            end
        end
    end
endmodule

// File: rtl/cpu_memory.sv
// Memory responder for the pipelined cpu: boot loader FSM, write-port mux and gated read ports.
module cpu_memory
    import cpu_mem_pkg::*;
#(
    parameter bit PRELOAD = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              read_mem_ir,
    input  logic [ADDR_W-1:0] mem_radrs_ir,
    output logic [DATA_W-1:0] instruction_fetch,
    input  logic              read_mem_str,
    input  logic [ADDR_W-1:0] mem_radrs_ld,
    output logic [DATA_W-1:0] mem_store_data,
    input  logic              write_mem,
    input  logic [ADDR_W-1:0] mem_wadrs,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              cpu_resetn,
    output logic              load_done
);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_next;
    logic              run;
    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata_mux;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= PRELOAD ? LOAD : RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == LOAD && accept &&
            (load_last || load_count[ADDR_W-1:0] == LAST_ADDR)) begin
            state_next = RUN;
        end
    end

    always_comb begin
        load_ready = (state == LOAD);
        load_done  = (state == RUN);
        run        = (state == RUN);
    end

    assign accept = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            load_count <= '0;
        end else if (accept && load_count != COUNT_MAX) begin
            load_count <= load_count + 1'b1;
        end
    end

    // Released one edge after RUN is entered so the cpu leaves reset cleanly.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cpu_resetn <= 1'b0;
        end else begin
            cpu_resetn <= run;
        end
    end

    always_comb begin
        mem_we        = 1'b0;
        mem_waddr     = mem_wadrs;
        mem_wdata_mux = mem_wdata;
        if (resetn) begin
            if (run) begin
                mem_we = write_mem;
            end else begin
                mem_we        = accept;
                mem_waddr     = load_count[ADDR_W-1:0];
                mem_wdata_mux = load_data;
            end
        end
    end

    mem_array_1w2r #(
        .AW(ADDR_W),
        .DW(DATA_W)
    ) u_mem (
        .clk    (clk),
        .resetn (resetn),
        .we     (mem_we),
        .waddr  (mem_waddr),
        .wdata  (mem_wdata_mux),
        .re_a   (run && read_mem_ir),
        .raddr_a(mem_radrs_ir),
        .rdata_a(instruction_fetch),
        .re_b   (run && read_mem_str),
        .raddr_b(mem_radrs_ld),
        .rdata_b(mem_store_data)
    );
endmodule

// File: tb/tb_cpu_memory.sv
// Directed bench for cpu_memory with a map-based reference model checked every cycle.
module tb_cpu_memory;
    import cpu_mem_pkg::*;

    logic              clk = 1'b0;
    logic              resetn;
    logic              read_mem_ir;
    logic [ADDR_W-1:0] mem_radrs_ir;
    logic [DATA_W-1:0] instruction_fetch;
    logic              read_mem_str;
    logic [ADDR_W-1:0] mem_radrs_ld;
    logic [DATA_W-1:0] mem_store_data;
    logic              write_mem;
    logic [ADDR_W-1:0] mem_wadrs;
    logic [DATA_W-1:0] mem_wdata;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic [ADDR_W:0]   load_count;
    logic              cpu_resetn;
    logic              load_done;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_memory #(.PRELOAD(1'b1)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .read_mem_ir      (read_mem_ir),
        .mem_radrs_ir     (mem_radrs_ir),
        .instruction_fetch(instruction_fetch),
        .read_mem_str     (read_mem_str),
        .mem_radrs_ld     (mem_radrs_ld),
        .mem_store_data   (mem_store_data),
        .write_mem        (write_mem),
        .mem_wadrs        (mem_wadrs),
        .mem_wdata        (mem_wdata),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .load_last        (load_last),
        .load_ready       (load_ready),
        .load_count       (load_count),
        .cpu_resetn       (cpu_resetn),
        .load_done        (load_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a map of written words, loader as a counter and a run flag.
    logic [31:0] model_mem [int];
    bit          m_init = 0;
    bit          m_run;
    int          m_count;
    bit          m_cpu_rn;
    logic [31:0] m_if, m_ld;
    bit          k_if, k_ld;

    always @(posedge clk) begin
        if (!resetn) begin
            m_init   = 1;
            m_run    = 0;
            m_count  = 0;
            m_cpu_rn = 0;
            m_if     = 0;
            m_ld     = 0;
            k_if     = 1;
            k_ld     = 1;
        end else if (m_init) begin
            m_cpu_rn = m_run;
            if (m_run) begin
                if (write_mem) model_mem[int'(mem_wadrs)] = mem_wdata;
                if (read_mem_ir) begin
                    k_if = model_mem.exists(int'(mem_radrs_ir));
                    if (k_if) m_if = model_mem[int'(mem_radrs_ir)];
                end
                if (read_mem_str) begin
                    k_ld = model_mem.exists(int'(mem_radrs_ld));
                    if (k_ld) m_ld = model_mem[int'(mem_radrs_ld)];
                end
            end else if (load_valid) begin
                model_mem[m_count] = load_data;
                m_count = m_count + 1;
                if (load_last || m_count == DEPTH) m_run = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("load_ready", {31'b0, load_ready}, {31'b0, !m_run});
            check("load_done", {31'b0, load_done}, {31'b0, m_run});
            check("cpu_resetn", {31'b0, cpu_resetn}, {31'b0, m_cpu_rn});
            check("load_count", {20'b0, load_count}, m_count);
            if (k_if) check("instruction_fetch", instruction_fetch, m_if);
            if (k_ld) check("mem_store_data", mem_store_data, m_ld);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        read_mem_ir  = 0; mem_radrs_ir = '0;
        read_mem_str = 0; mem_radrs_ld = '0;
        write_mem    = 0; mem_wadrs    = '0; mem_wdata = '0;
        load_valid   = 0; load_data    = '0; load_last = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        tick(2);
        resetn = 1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        load_valid = 1; load_data = d; load_last = last;
        tick();
        load_valid = 0; load_last = 0;
    endtask

    task automatic read_ld(input logic [ADDR_W-1:0] a);
        read_mem_str = 1; mem_radrs_ld = a;
        tick();
        read_mem_str = 0;
    endtask

    initial begin
        logic [31:0] words [4];
        words = '{32'h11, 32'h22, 32'h33, 32'h44};

        do_reset();
        // CPU reads during LOAD must be ignored
        read_mem_ir = 1; mem_radrs_ir = 11'd3;
        tick(10);
        read_mem_ir = 0;
        check("reset_cpu_resetn", {31'b0, cpu_resetn}, 32'd0);
        check("reset_load_ready", {31'b0, load_ready}, 32'd1);
        check("reset_load_count", {20'b0, load_count}, 32'd0);
        check("reset_if", instruction_fetch, 32'd0);
        check("reset_ld", mem_store_data, 32'd0);

        push_word(words[0], 0);
        push_word(words[1], 0);
        tick();
        push_word(words[2], 0);
        push_word(words[3], 1);
        check("boot_count", {20'b0, load_count}, 32'd4);
        check("boot_done", {31'b0, load_done}, 32'd1);
        check("boot_cpu_rn_lag", {31'b0, cpu_resetn}, 32'd0);
        tick();
        check("boot_cpu_rn", {31'b0, cpu_resetn}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            read_mem_ir = 1; mem_radrs_ir = ADDR_W'(i);
            tick();
            check("boot_fetch", instruction_fetch, words[i]);
        end
        read_mem_ir = 0;

        write_mem = 1; mem_wadrs = 11'd5; mem_wdata = 32'hDEADBEEF;
        tick();
        write_mem = 0;
        tick();
        read_ld(11'd5);
        check("store_load", mem_store_data, 32'hDEADBEEF);
        tick(2);
        check("store_hold", mem_store_data, 32'hDEADBEEF);

        write_mem = 1; mem_wadrs = 11'd7; mem_wdata = 32'hA5A5A5A5;
        read_mem_ir = 1; mem_radrs_ir = 11'd7;
        read_mem_str = 1; mem_radrs_ld = 11'd7;
        tick();
        idle_inputs();
        check("collide_if", instruction_fetch, 32'hA5A5A5A5);
        check("collide_ld", mem_store_data, 32'hA5A5A5A5);
        read_mem_ir = 1; mem_radrs_ir = 11'd1;
        read_mem_str = 1; mem_radrs_ld = 11'd2;
        tick();
        idle_inputs();
        check("dual_if", instruction_fetch, 32'h22);
        check("dual_ld", mem_store_data, 32'h33);

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1; load_data = 32'h1000_0000 + i; load_last = 0;
            tick();
        end
        check("full_count", {20'b0, load_count}, 32'd2048);
        check("full_done", {31'b0, load_done}, 32'd1);
        load_data = 32'hFFFFFFFF;
        tick();
        load_valid = 0;
        check("extra_count", {20'b0, load_count}, 32'd2048);
        read_ld(11'd0);
        check("extra_addr0", mem_store_data, 32'h1000_0000);

        do_reset();
        push_word(32'h100, 0);
        push_word(32'h101, 0);
        push_word(32'h102, 0);
        do_reset();
        push_word(32'h99, 1);
        check("abort_count", {20'b0, load_count}, 32'd1);
        read_ld(11'd0);
        check("abort_addr0", mem_store_data, 32'h99);
        read_ld(11'd1);
        check("abort_addr1", mem_store_data, 32'h101);

        do_reset();
        write_mem = 1; mem_wadrs = 11'd10; mem_wdata = 32'h12345678;
        tick();
        write_mem = 0;
        push_word(32'h55, 1);
        read_ld(11'd10);
        check("load_write_ignored", mem_store_data, 32'h1000_000A);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
